// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate engine: one STEP-bit shift stage is reused each cycle
// until the requested amount is consumed, behind valid/ready ports on both sides.
module shift_sequencer #(
    parameter int N    = 8,
    parameter int STEP = 3,
    parameter int AW   = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_up_valid,
    output logic          o_up_ready,
    input  logic [N-1:0]  i_up_data,
    input  logic [AW-1:0] i_up_amt,
    input  logic [1:0]    i_up_op,
    output logic          o_down_valid,
    input  logic          i_down_ready,
    output logic [N-1:0]  o_down_data,
    output logic          o_busy
);

    localparam logic [1:0]    OP_LSL  = 2'b00;
    localparam logic [1:0]    OP_LSR  = 2'b01;
    localparam logic [1:0]    OP_ASR  = 2'b10;
    localparam logic [1:0]    OP_ROL  = 2'b11;
    localparam logic [AW-1:0] N_AW    = AW'(N);
    localparam logic [AW-1:0] STEP_AW = AW'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_data;
    logic [AW-1:0] r_rem;
    logic [1:0]    r_op;
    logic          r_up_ready;
    logic          r_down_valid;
    logic [N-1:0]  r_down_data;
    logic          r_busy;

    logic [AW-1:0] w_amt_sat;
    logic [AW-1:0] w_amt_mod;
    logic [AW-1:0] w_eff;
    logic [AW-1:0] w_k;
    logic [N-1:0]  w_shifted;
    logic [STEP:1][N-1:0] w_stage;

    // Saturating the shift amount at N keeps every stage index in range.
    assign w_amt_sat = (i_up_amt > N_AW) ? N_AW : i_up_amt;
    assign w_amt_mod = i_up_amt % N_AW;
    assign w_eff     = (i_up_op == OP_ROL) ? w_amt_mod : w_amt_sat;

    assign w_k = (r_rem > STEP_AW) ? STEP_AW : r_rem;

    genvar gi;
    generate
        for (gi = 1; gi <= STEP; gi++) begin : g_stage
            assign w_stage[gi] =
                (r_op == OP_LSL) ? (r_data << gi) :
                (r_op == OP_LSR) ? (r_data >> gi) :
                (r_op == OP_ASR) ? N'($signed(r_data) >>> gi) :
                                   ((r_data << gi) | (r_data >> (N - gi)));
        end
    endgenerate

    always_comb begin
        w_shifted = r_data;
        for (int j = 1; j <= STEP; j++) begin
            if (w_k == AW'(j)) begin
                w_shifted = w_stage[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_data       <= '0;
            r_rem        <= '0;
            r_op         <= OP_LSL;
            r_up_ready   <= 1'b1;
            r_down_valid <= 1'b0;
            r_down_data  <= '0;
            r_busy       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_up_valid) begin
                        r_data     <= i_up_data;
                        r_op       <= i_up_op;
                        r_rem      <= w_eff;
                        r_up_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_eff == '0) begin
                            r_state      <= S_DONE;
                            r_down_valid <= 1'b1;
                            r_down_data  <= i_up_data;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_data <= w_shifted;
                    r_rem  <= r_rem - w_k;
                    if (r_rem == w_k) begin
                        r_state      <= S_DONE;
                        r_down_valid <= 1'b1;
                        r_down_data  <= w_shifted;
                    end
                end
                S_DONE: begin
                    // The result register is left untouched so it stays stable under backpressure.
                    if (i_down_ready) begin
                        r_state      <= S_IDLE;
                        r_down_valid <= 1'b0;
                        r_up_ready   <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_down_valid <= 1'b0;
                    r_up_ready   <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_up_ready   = r_up_ready;
    assign o_down_valid = r_down_valid;
    assign o_down_data  = r_down_data;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and back-to-back checks of shift_sequencer (N=8, STEP=3) with
// immediate assertions at every comparison point.
module tb_shift_sequencer;

    localparam int N    = 8;
    localparam int STEP = 3;
    localparam int AW   = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_up_valid = 1'b0;
    logic          o_up_ready;
    logic [N-1:0]  i_up_data = '0;
    logic [AW-1:0] i_up_amt = '0;
    logic [1:0]    i_up_op = 2'b00;
    logic          o_down_valid;
    logic          i_down_ready = 1'b0;
    logic [N-1:0]  o_down_data;
    logic          o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    shift_sequencer #(.N(N), .STEP(STEP), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_up_valid   (i_up_valid),
        .o_up_ready   (o_up_ready),
        .i_up_data    (i_up_data),
        .i_up_amt     (i_up_amt),
        .i_up_op      (i_up_op),
        .o_down_valid (o_down_valid),
        .i_down_ready (i_down_ready),
        .o_down_data  (o_down_data),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit-at-a-time reference, independent of the chunked hardware stage.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt, input logic [1:0] op);
        int e;
        e = (op == 2'b11) ? (amt % 8) : ((amt > 8) ? 8 : amt);
        for (int s = 0; s < e; s++) begin
            case (op)
                2'b00:   d = {d[6:0], 1'b0};
                2'b01:   d = {1'b0, d[7:1]};
                2'b10:   d = {d[7], d[7:1]};
                default: d = {d[6:0], d[7]};
            endcase
        end
        return d;
    endfunction

    function automatic int ref_lat(input int amt, input logic [1:0] op);
        int e;
        e = (op == 2'b11) ? (amt % 8) : ((amt > 8) ? 8 : amt);
        return 1 + (e + STEP - 1) / STEP;
    endfunction

    task automatic wait_ready();
        int t;
        t = 0;
        while (!o_up_ready && t < 40) begin
            @(posedge clk); #1; t++;
        end
    endtask

    // Called #1 after the acceptance edge; n = further edges until down_valid.
    task automatic wait_valid(output int n);
        n = 0;
        while (!o_down_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic run_req(input string tag, input logic [7:0] d, input int amt,
                           input logic [1:0] op, input logic [7:0] exp_d, input int exp_lat);
        int n;
        wait_ready();
        i_up_data  = d;
        i_up_amt   = AW'(amt);
        i_up_op    = op;
        i_up_valid = 1'b1;
        @(posedge clk); #1;
        i_up_valid = 1'b0;
        check({tag, "_busy"}, o_busy, 1);
        wait_valid(n);
        check({tag, "_lat"}, n + 1, exp_lat);
        check({tag, "_data"}, o_down_data, exp_d);
        i_down_ready = 1'b1;
        @(posedge clk); #1;
        i_down_ready = 1'b0;
        check({tag, "_vld_drop"}, o_down_valid, 0);
        check({tag, "_rdy_back"}, o_up_ready, 1);
        $display("%s: data=0x%02h amt=%0d op=%0d -> 0x%02h latency %0d", tag, d, amt, op, o_down_data, n + 1);
    endtask

    logic [7:0]    rnd_d   [10];
    int            rnd_amt [10];
    logic [1:0]    rnd_op  [10];

    initial begin
        int n;
        logic [7:0] held;

        #22;
        check("rst_up_ready", o_up_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_down_valid", o_down_valid, 0);
        check("rst_down_data", o_down_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_req("lsl_b5_3",  8'hB5, 3,  2'b00, 8'hA8, 2);
        run_req("lsr_b5_7",  8'hB5, 7,  2'b01, 8'h01, 4);
        run_req("asr_b5_12", 8'hB5, 12, 2'b10, 8'hFF, 4);
        run_req("asr_35_2",  8'h35, 2,  2'b10, 8'h0D, 2);
        run_req("rol_b5_11", 8'hB5, 11, 2'b11, 8'hAD, 2);
        run_req("rol_b5_8",  8'hB5, 8,  2'b11, 8'hB5, 1);
        run_req("lsl_b5_15", 8'hB5, 15, 2'b00, 8'h00, 4);

        // Backpressure with a competing request held on the upstream port.
        wait_ready();
        i_up_data = 8'hB5; i_up_amt = AW'(3); i_up_op = 2'b00; i_up_valid = 1'b1;
        @(posedge clk); #1;
        i_up_data = 8'hF0; i_up_amt = AW'(4); i_up_op = 2'b01;
        wait_valid(n);
        check("bp_lat", n + 1, 2);
        held = o_down_data;
        check("bp_data", held, 8'hA8);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_hold_data", o_down_data, 8'hA8);
            check("bp_hold_valid", o_down_valid, 1);
            check("bp_up_ready", o_up_ready, 0);
        end
        $display("backpressure: held 0x%02h for 5 cycles", held);
        i_down_ready = 1'b1;
        @(posedge clk); #1;
        i_down_ready = 1'b0;
        check("bp_no_accept_on_handshake", o_busy, 0);
        check("bp_rdy_after_handshake", o_up_ready, 1);
        @(posedge clk); #1;
        i_up_valid = 1'b0;
        check("bp_second_accepted", o_busy, 1);
        wait_valid(n);
        check("bp2_lat", n + 1, 3);
        check("bp2_data", o_down_data, 8'h0F);
        i_down_ready = 1'b1;
        @(posedge clk); #1;
        i_down_ready = 1'b0;
        $display("backpressure second request: LSR 0xF0 by 4 -> 0x%02h", o_down_data);

        // Asynchronous reset asserted between edges in the middle of SHIFT.
        run_req("lsl_pre_rst", 8'h81, 1, 2'b00, 8'h02, 2);
        wait_ready();
        i_up_data = 8'hC3; i_up_amt = AW'(8); i_up_op = 2'b01; i_up_valid = 1'b1;
        @(posedge clk); #1;
        i_up_valid = 1'b0;
        @(posedge clk); #2;
        check("mid_shift_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_down_valid", o_down_valid, 0);
        check("arst_busy", o_busy, 0);
        check("arst_up_ready", o_up_ready, 1);
        check("arst_down_data", o_down_data, 0);
        $display("async reset mid-shift: valid=%0d busy=%0d ready=%0d data=0x%02h",
                 o_down_valid, o_busy, o_up_ready, o_down_data);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_req("post_rst_lsl", 8'h01, 1, 2'b00, 8'h02, 2);

        // Back-to-back random requests with up_valid and down_ready held high.
        for (int i = 0; i < 10; i++) begin
            rnd_d[i]   = 8'($urandom);
            rnd_amt[i] = int'($urandom_range(0, 15));
            rnd_op[i]  = 2'($urandom_range(0, 3));
        end
        i_down_ready = 1'b1;
        i_up_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_up_data = rnd_d[i];
            i_up_amt  = AW'(rnd_amt[i]);
            i_up_op   = rnd_op[i];
            wait_ready();
            check("b2b_ready", o_up_ready, 1);
            @(posedge clk); #1;
            wait_valid(n);
            check("b2b_lat", n + 1, ref_lat(rnd_amt[i], rnd_op[i]));
            check("b2b_data", o_down_data, ref_shift(rnd_d[i], rnd_amt[i], rnd_op[i]));
            $display("b2b[%0d]: data=0x%02h amt=%0d op=%0d -> 0x%02h latency %0d",
                     i, rnd_d[i], rnd_amt[i], rnd_op[i], o_down_data, n + 1);
        end
        i_up_valid = 1'b0;
        @(posedge clk); #1;
        i_down_ready = 1'b0;
        @(posedge clk); #1;
        check("final_idle", o_busy, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller that executes arbitrary-amount shift and rotate requests with one fixed-width stage that shifts at most STEP bits per cycle. It iterates the stage until the requested amount is consumed. Requests arrive on a valid/ready upstream port and results leave on a valid/ready downstream port. It sits between an instruction or packet front end and consumers that need variable shifts without a full N-bit barrel shifter.

## Interface
- N, 8: data width in bits (N ≥ 2).
- STEP, 3: maximum bits shifted per iteration cycle (1 ≤ STEP ≤ N).
- AW, $clog2(N)+1: width of the shift-amount field.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- up_valid  input  1  a request is present.
- up_ready  output  1  block accepts a request this cycle.
- up_data  input  N  operand.
- up_amt  input  AW  requested shift amount (unsigned, 0..2^AW-1).
- up_op  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
- down_valid  output  1  result is available.
- down_ready  input  1  consumer takes the result this cycle.
- down_data  output  N  result.
- busy  output  1  a request is accepted and its result has not yet been consumed.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (rst_n low): state = IDLE, data and remaining-count registers = 0, down_valid = 0, down_data = 0, busy = 0, up_ready = 1. Reset takes effect immediately, regardless of clock. Any in-flight request is discarded; no result is emitted for it.
- up_ready = (state == IDLE). The block accepts a request on a clock edge where up_valid && up_ready.
- Effective amount E is computed at acceptance:
  - LSL, LSR, ASR: E = min(up_amt, N).
  - ROL: E = up_amt mod N.
- Acceptance loads the operand, op and E into registers. Next state is DONE if E == 0, otherwise SHIFT.
- SHIFT: each cycle computes k = min(remaining, STEP), then:
  - shifts the data register by k (LSL and LSR fill with zero; ASR fills with the register's bit N-1; ROL rotates left);
  - sets remaining -= k;
  - moves to DONE when remaining becomes 0.
- DONE: down_valid = 1 and down_data = the data register. Leave DONE for IDLE on an edge where down_ready = 1.
- down_data is held stable while down_valid && !down_ready. Output ports are never X after reset.
- busy = (state != IDLE).
- Simultaneous events:
  - up_valid in any state other than IDLE is ignored. The requester must hold the request.
  - No new request is accepted in the same cycle as a downstream handshake.
- Arithmetic: shifting by N yields 0 for LSL and LSR, and all sign bits for ASR. up_amt ≥ N never produces an out-of-range index.

## Timing
- For a request accepted at edge T:
  - E == 0: down_valid is high from T+1.
  - E > 0: SHIFT occupies ceil(E/STEP) cycles, and down_valid is high from T+1+ceil(E/STEP).
- Result is handed over at the first edge with down_valid && down_ready. up_ready returns high in the following cycle.
- Minimum request-to-request spacing is latency + 1 cycles, where latency is the T-to-down_valid delay above. Throughput with down_ready held high: one result per ceil(E/STEP)+2 cycles.
- No combinational path from up_* to down_*. up_ready depends only on state; down_ready affects only the next state.

## Test plan
- Reset: rst_n low mid-SHIFT, asserted between clock edges → immediately down_valid = 0, busy = 0, up_ready = 1, down_data = 0. After release, a fresh LSL 0x01 by 1 → 0x02.
- LSL 0xB5 by 3 (N=8, STEP=3), accepted at T → down_data = 0xA8, down_valid high from T+2. LSR 0xB5 by 7 → 0x01, valid from T+4.
- ASR 0xB5 by 12 (saturates to 8) → 0xFF, valid from T+4. ASR 0x35 by 2 → 0x0D.
- ROL 0xB5 by 11 (E = 3) → 0xAD, valid from T+2. ROL by 8 (E = 0) → 0xB5, valid from T+1.
- Backpressure: down_ready held low 5 cycles after down_valid → down_data stable, up_ready = 0. A second request held on up_valid is not accepted until the cycle after the down handshake.
- Back-to-back: with down_ready = 1, 10 random requests with up_valid always high → every result matches the reference shift model, and per-request latency matches ceil(E/STEP)+1.
